// File: rtl/bwt_req_arbiter.sv
// Arbitrates forward/backward BWT k/l lookups onto one memory port.
// Each requester owns a one-entry buffer; a granted entry issues k then l, gated by outstanding credits.
module bwt_req_arbiter #(
   parameter int unsigned ADDR_W  = 42,
   parameter int unsigned RN_W    = 9,
   parameter int unsigned MAX_OUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req_valid,
   input  logic [ADDR_W-1:0] f_addr_k,
   input  logic [ADDR_W-1:0] f_addr_l,
   input  logic [RN_W-1:0]   f_read_num,
   input  logic              b_req_valid,
   input  logic [ADDR_W-1:0] b_addr_k,
   input  logic [ADDR_W-1:0] b_addr_l,
   input  logic [RN_W-1:0]   b_read_num,
   output logic              f_stall,
   output logic              b_stall,
   output logic              mem_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [RN_W+1:0]   mem_tag,
   input  logic              mem_ready,
   input  logic              resp_valid,
   output logic              busy,
   output logic              err_underflow
);

   typedef enum logic [1:0] {IDLE, ISSUE_K, ISSUE_L} state_t;

   localparam logic [5:0] MAX_CNT = 6'(MAX_OUT);

   state_t              state_q;
   logic                f_full_q, b_full_q;
   logic [ADDR_W-1:0]   f_k_q, f_l_q, b_k_q, b_l_q;
   logic [RN_W-1:0]     f_rn_q, b_rn_q;
   logic                gnt_b_q, last_b_q;
   logic                mem_valid_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [RN_W+1:0]     mem_tag_q;
   logic [5:0]          cnt_q, cnt_d;
   logic                err_q;
   logic                hs, f_load, b_load, pick_b, cnt_room;

   assign hs     = mem_valid_q & mem_ready;
   assign f_load = f_req_valid & ~f_full_q;
   assign b_load = b_req_valid & ~b_full_q;
   // Backward wins only if forward is empty or forward was granted last.
   assign pick_b = b_full_q & (~f_full_q | ~last_b_q);

   always_comb begin
      cnt_d = cnt_q;
      if (hs && !resp_valid)
         cnt_d = cnt_q + 6'd1;
      else if (!hs && resp_valid && cnt_q != '0)
         cnt_d = cnt_q - 6'd1;
   end

   // Valid is registered, so the credit check looks at next cycle's count.
   assign cnt_room = (cnt_d < MAX_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (resp_valid && cnt_q == '0)
            err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f_k_q  <= '0;
         f_l_q  <= '0;
         f_rn_q <= '0;
         b_k_q  <= '0;
         b_l_q  <= '0;
         b_rn_q <= '0;
      end else begin
         if (f_load) begin
            f_k_q  <= f_addr_k;
            f_l_q  <= f_addr_l;
            f_rn_q <= f_read_num;
         end
         if (b_load) begin
            b_k_q  <= b_addr_k;
            b_l_q  <= b_addr_l;
            b_rn_q <= b_read_num;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         f_full_q    <= 1'b0;
         b_full_q    <= 1'b0;
         gnt_b_q     <= 1'b0;
         last_b_q    <= 1'b1;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_tag_q   <= '0;
      end else begin
         if (f_load) f_full_q <= 1'b1;
         if (b_load) b_full_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (f_full_q || b_full_q) begin
                  gnt_b_q     <= pick_b;
                  mem_addr_q  <= pick_b ? b_k_q : f_k_q;
                  mem_tag_q   <= {pick_b, (pick_b ? b_rn_q : f_rn_q), 1'b0};
                  mem_valid_q <= cnt_room;
                  state_q     <= ISSUE_K;
               end
            end
            ISSUE_K: begin
               mem_valid_q <= cnt_room;
               if (hs) begin
                  mem_addr_q   <= gnt_b_q ? b_l_q : f_l_q;
                  mem_tag_q[0] <= 1'b1;
                  state_q      <= ISSUE_L;
               end
            end
            ISSUE_L: begin
               if (hs) begin
                  if (gnt_b_q) b_full_q <= 1'b0;
                  else         f_full_q <= 1'b0;
                  last_b_q    <= gnt_b_q;
                  mem_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  mem_valid_q <= cnt_room;
               end
            end
            default: begin
               mem_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign f_stall       = f_full_q;
   assign b_stall       = b_full_q;
   assign mem_valid     = mem_valid_q;
   assign mem_addr      = mem_addr_q;
   assign mem_tag       = mem_tag_q;
   assign busy          = (state_q != IDLE) | f_full_q | b_full_q;
   assign err_underflow = err_q;

endmodule

// File: tb/tb_bwt_req_arbiter.sv
// Bench for bwt_req_arbiter: directed vector table, ordering/credit sequences, and random traffic
// checked against a queue-based transaction model.
module tb_bwt_req_arbiter;

   localparam int AW = 42;
   localparam int RW = 9;
   localparam int MO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          f_req_valid, b_req_valid;
   logic [AW-1:0] f_addr_k, f_addr_l, b_addr_k, b_addr_l;
   logic [RW-1:0] f_read_num, b_read_num;
   logic          mem_ready, resp_valid;
   logic          f_stall, b_stall, mem_valid, busy, err_underflow;
   logic [AW-1:0] mem_addr;
   logic [RW+1:0] mem_tag;
   logic          f_stall2, b_stall2, mem_valid2, busy2, err2;
   logic [AW-1:0] mem_addr2;
   logic [RW+1:0] mem_tag2;

   always #5 clk = ~clk;

   bwt_req_arbiter #(.ADDR_W(AW), .RN_W(RW), .MAX_OUT(MO)) u_dut (
      .clk(clk), .rst(rst),
      .f_req_valid(f_req_valid), .f_addr_k(f_addr_k), .f_addr_l(f_addr_l), .f_read_num(f_read_num),
      .b_req_valid(b_req_valid), .b_addr_k(b_addr_k), .b_addr_l(b_addr_l), .b_read_num(b_read_num),
      .f_stall(f_stall), .b_stall(b_stall),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_tag(mem_tag), .mem_ready(mem_ready),
      .resp_valid(resp_valid), .busy(busy), .err_underflow(err_underflow)
   );

   bwt_req_arbiter #(.ADDR_W(AW), .RN_W(RW), .MAX_OUT(2)) u_dut2 (
      .clk(clk), .rst(rst),
      .f_req_valid(f_req_valid), .f_addr_k(f_addr_k), .f_addr_l(f_addr_l), .f_read_num(f_read_num),
      .b_req_valid(b_req_valid), .b_addr_k(b_addr_k), .b_addr_l(b_addr_l), .b_read_num(b_read_num),
      .f_stall(f_stall2), .b_stall(b_stall2),
      .mem_valid(mem_valid2), .mem_addr(mem_addr2), .mem_tag(mem_tag2), .mem_ready(mem_ready),
      .resp_valid(resp_valid), .busy(busy2), .err_underflow(err2)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { logic [AW-1:0] k; logic [AW-1:0] l; logic [RW-1:0] rn; } req_t;
   req_t fq[$];
   req_t bq[$];
   int   phase = 0;       // 0: no transaction, 1: k half pending, 2: l half pending
   bit   cur_b = 0;
   bit   last_b = 1;
   int   m_out = 0;
   bit   m_err = 0;
   bit   m_valid = 0;
   bit   after_rst = 0;

   task automatic model_edge();
      bit   hs;
      bit   f_acc, b_acc;
      req_t r;
      if (rst) begin
         fq.delete(); bq.delete();
         phase = 0; last_b = 1; m_out = 0; m_err = 0; m_valid = 0; after_rst = 1;
      end else begin
         after_rst = 0;
         hs    = m_valid && mem_ready;
         f_acc = f_req_valid && fq.size() == 0;
         b_acc = b_req_valid && bq.size() == 0;
         if (resp_valid && m_out == 0) m_err = 1;
         if (hs && !resp_valid) m_out++;
         else if (!hs && resp_valid && m_out > 0) m_out--;
         if (phase == 0) begin
            if (fq.size() != 0 && bq.size() != 0) begin cur_b = !last_b; phase = 1; end
            else if (fq.size() != 0) begin cur_b = 0; phase = 1; end
            else if (bq.size() != 0) begin cur_b = 1; phase = 1; end
         end else if (phase == 1) begin
            if (hs) phase = 2;
         end else if (hs) begin
            if (cur_b) void'(bq.pop_front());
            else       void'(fq.pop_front());
            last_b = cur_b;
            phase  = 0;
         end
         if (f_acc) begin r.k = f_addr_k; r.l = f_addr_l; r.rn = f_read_num; fq.push_back(r); end
         if (b_acc) begin r.k = b_addr_k; r.l = b_addr_l; r.rn = b_read_num; bq.push_back(r); end
         m_valid = (phase != 0) && (m_out < MO);
      end
   endtask

   task automatic model_cmp();
      req_t          h;
      logic [AW-1:0] ea;
      logic [RW+1:0] et;
      chk("m.f_stall", f_stall, fq.size() != 0);
      chk("m.b_stall", b_stall, bq.size() != 0);
      chk("m.mem_valid", mem_valid, m_valid);
      chk("m.busy", busy, (phase != 0) || fq.size() != 0 || bq.size() != 0);
      chk("m.err_underflow", err_underflow, m_err);
      if (after_rst) begin
         chk("m.rst_addr", mem_addr, 0);
         chk("m.rst_tag", mem_tag, 0);
      end else if (m_valid) begin
         h  = cur_b ? bq[0] : fq[0];
         ea = (phase == 1) ? h.k : h.l;
         et = {cur_b, h.rn, (phase == 2)};
         chk("m.mem_addr", mem_addr, ea);
         chk("m.mem_tag", mem_tag, et);
      end
   endtask

   logic [RW+1:0] tag_log[$];
   int            hs2_cnt = 0;

   task automatic step();
      if (mem_valid && mem_ready) tag_log.push_back(mem_tag);
      if (mem_valid2 && mem_ready) hs2_cnt++;
      @(posedge clk);
      model_edge();
      #1;
      model_cmp();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit            r, fv, bv, rdy, rsp;
      logic [AW-1:0] fk, fl, bk, bl;
      logic [RW-1:0] frn, brn;
      bit            efs, ebs, ev, ebusy, eerr, ca;
      logic [AW-1:0] ea;
      logic [RW+1:0] et;
   } vec_t;

   function automatic vec_t mk(input bit r, fv, bv, rdy, rsp,
                               input logic [AW-1:0] fk, fl, input logic [RW-1:0] frn,
                               input logic [AW-1:0] bk, bl, input logic [RW-1:0] brn,
                               input bit efs, ebs, ev, ebusy, eerr, ca,
                               input logic [AW-1:0] ea, input logic [RW+1:0] et);
      vec_t v;
      v.r = r; v.fv = fv; v.bv = bv; v.rdy = rdy; v.rsp = rsp;
      v.fk = fk; v.fl = fl; v.frn = frn; v.bk = bk; v.bl = bl; v.brn = brn;
      v.efs = efs; v.ebs = ebs; v.ev = ev; v.ebusy = ebusy; v.eerr = eerr; v.ca = ca;
      v.ea = ea; v.et = et;
      return v;
   endfunction

   vec_t vecs[$];

   initial begin
      //                 r  fv bv rdy rsp  fk     fl     frn   bk     bl     brn    fs bs v  by er ca  addr   tag
      vecs.push_back(mk(1, 0, 0, 0, 0,  42'h0, 42'h0, 9'h0, 42'h0, 42'h0, 9'h0,  0, 0, 0, 0, 0, 1, 42'h0, 11'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0,  42'h10,42'h20,9'h5, 42'h0, 42'h0, 9'h0,  1, 0, 0, 1, 0, 0, 42'h0, 11'h0));
      vecs.push_back(mk(0, 0, 0, 1, 0,  42'h10,42'h20,9'h5, 42'h0, 42'h0, 9'h0,  1, 0, 1, 1, 0, 1, 42'h10,11'h00A));
      vecs.push_back(mk(0, 0, 0, 1, 0,  42'h10,42'h20,9'h5, 42'h0, 42'h0, 9'h0,  1, 0, 1, 1, 0, 1, 42'h20,11'h00B));
      vecs.push_back(mk(0, 0, 0, 1, 0,  42'h10,42'h20,9'h5, 42'h0, 42'h0, 9'h0,  0, 0, 0, 0, 0, 0, 42'h0, 11'h0));
      vecs.push_back(mk(0, 0, 0, 0, 1,  42'h0, 42'h0, 9'h0, 42'h0, 42'h0, 9'h0,  0, 0, 0, 0, 0, 0, 42'h0, 11'h0));
      vecs.push_back(mk(0, 0, 0, 0, 1,  42'h0, 42'h0, 9'h0, 42'h0, 42'h0, 9'h0,  0, 0, 0, 0, 0, 0, 42'h0, 11'h0));
      vecs.push_back(mk(0, 0, 0, 0, 1,  42'h0, 42'h0, 9'h0, 42'h0, 42'h0, 9'h0,  0, 0, 0, 0, 1, 0, 42'h0, 11'h0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  42'h0, 42'h0, 9'h0, 42'h0, 42'h0, 9'h0,  0, 0, 0, 0, 1, 0, 42'h0, 11'h0));
      vecs.push_back(mk(1, 0, 0, 0, 0,  42'h0, 42'h0, 9'h0, 42'h0, 42'h0, 9'h0,  0, 0, 0, 0, 0, 1, 42'h0, 11'h0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  42'h0, 42'h0, 9'h0, 42'h30,42'h40,9'h1FF,0, 1, 0, 1, 0, 0, 42'h0, 11'h0));
      for (int i = 0; i < 6; i++)
         vecs.push_back(mk(0, 0, 0, 0, 0, 42'h0, 42'h0, 9'h0, 42'h30,42'h40,9'h1FF,0, 1, 1, 1, 0, 1, 42'h30,11'h7FE));
      vecs.push_back(mk(0, 0, 0, 1, 0,  42'h0, 42'h0, 9'h0, 42'h30,42'h40,9'h1FF,0, 1, 1, 1, 0, 1, 42'h40,11'h7FF));
      vecs.push_back(mk(0, 0, 0, 1, 0,  42'h0, 42'h0, 9'h0, 42'h30,42'h40,9'h1FF,0, 0, 0, 0, 0, 0, 42'h0, 11'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0,  42'h1, 42'h2, 9'h3, 42'h0, 42'h0, 9'h0,  1, 0, 0, 1, 0, 0, 42'h0, 11'h0));
      vecs.push_back(mk(0, 0, 0, 1, 0,  42'h1, 42'h2, 9'h3, 42'h0, 42'h0, 9'h0,  1, 0, 1, 1, 0, 1, 42'h1, 11'h006));
      vecs.push_back(mk(0, 0, 0, 1, 0,  42'h1, 42'h2, 9'h3, 42'h0, 42'h0, 9'h0,  1, 0, 1, 1, 0, 1, 42'h2, 11'h007));
      vecs.push_back(mk(1, 1, 0, 1, 0,  42'h9, 42'h9, 9'h9, 42'h0, 42'h0, 9'h0,  0, 0, 0, 0, 0, 1, 42'h0, 11'h0));
      vecs.push_back(mk(0, 0, 0, 1, 0,  42'h9, 42'h9, 9'h9, 42'h0, 42'h0, 9'h0,  0, 0, 0, 0, 0, 1, 42'h0, 11'h0));

      f_req_valid = 0; b_req_valid = 0; mem_ready = 0; resp_valid = 0; rst = 1;
      f_addr_k = '0; f_addr_l = '0; f_read_num = '0;
      b_addr_k = '0; b_addr_l = '0; b_read_num = '0;

      foreach (vecs[i]) begin
         rst = vecs[i].r; f_req_valid = vecs[i].fv; b_req_valid = vecs[i].bv;
         mem_ready = vecs[i].rdy; resp_valid = vecs[i].rsp;
         f_addr_k = vecs[i].fk; f_addr_l = vecs[i].fl; f_read_num = vecs[i].frn;
         b_addr_k = vecs[i].bk; b_addr_l = vecs[i].bl; b_read_num = vecs[i].brn;
         step();
         chk($sformatf("vec%0d.f_stall", i), f_stall, vecs[i].efs);
         chk($sformatf("vec%0d.b_stall", i), b_stall, vecs[i].ebs);
         chk($sformatf("vec%0d.mem_valid", i), mem_valid, vecs[i].ev);
         chk($sformatf("vec%0d.busy", i), busy, vecs[i].ebusy);
         chk($sformatf("vec%0d.err", i), err_underflow, vecs[i].eerr);
         if (vecs[i].ca) begin
            chk($sformatf("vec%0d.mem_addr", i), mem_addr, vecs[i].ea);
            chk($sformatf("vec%0d.mem_tag", i), mem_tag, vecs[i].et);
         end
      end

      // Both requesters continuously valid: pairs must alternate F,B,F,B with k before l.
      rst = 1; f_req_valid = 0; b_req_valid = 0; resp_valid = 0; mem_ready = 1;
      step();
      rst = 0;
      f_req_valid = 1; f_addr_k = 42'd100; f_addr_l = 42'd101; f_read_num = 9'd1;
      b_req_valid = 1; b_addr_k = 42'd200; b_addr_l = 42'd201; b_read_num = 9'd2;
      tag_log.delete();
      repeat (24) begin
         resp_valid = (m_out > 0);
         step();
      end
      chk("rr.count", tag_log.size() >= 8, 1);
      for (int i = 0; i < 8 && i < tag_log.size(); i++) begin
         logic src;
         logic [RW-1:0] rn;
         src = ((i / 2) % 2) == 1;
         rn  = src ? 9'd2 : 9'd1;
         chk($sformatf("rr.tag%0d", i), tag_log[i], {src, rn, (i % 2) == 1});
      end

      // Credit limit on the MAX_OUT=2 instance.
      rst = 1; resp_valid = 0;
      step();
      rst = 0; hs2_cnt = 0;
      repeat (12) step();
      chk("credit.first_burst", hs2_cnt, 2);
      chk("credit.valid_blocked", mem_valid2, 0);
      hs2_cnt = 0;
      resp_valid = 1;
      step();
      resp_valid = 0;
      repeat (10) step();
      chk("credit.after_resp", hs2_cnt, 1);
      chk("credit.valid_blocked2", mem_valid2, 0);
      chk("credit.no_err", err2, 0);

      // Random traffic against the model.
      rst = 1; f_req_valid = 0; b_req_valid = 0;
      step();
      rst = 0;
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 249) == 0);
         if (!f_stall) begin
            f_req_valid = $urandom_range(0, 1) == 1;
            f_addr_k    = AW'({$urandom, $urandom});
            f_addr_l    = AW'({$urandom, $urandom});
            f_read_num  = RW'($urandom);
         end
         if (!b_stall) begin
            b_req_valid = $urandom_range(0, 1) == 1;
            b_addr_k    = AW'({$urandom, $urandom});
            b_addr_l    = AW'({$urandom, $urandom});
            b_read_num  = RW'($urandom);
         end
         mem_ready  = $urandom_range(0, 9) < 7;
         resp_valid = $urandom_range(0, 9) < 3;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bwt_req_arbiter.md
BWT_REQ_ARBITER -- requirements
Module: bwt_req_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, default 42, BWT address width; RN_W, default 9, read-number width; MAX_OUT, default 16, maximum outstanding memory requests (range 1..63).
REQ-002 SHALL have a single clock and a synchronous, active-high reset; no other clock or reset.
REQ-003 clk  in  1  clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 f_req_valid  in  1  forward pipeline k/l request.
REQ-006 f_addr_k, f_addr_l  in  ADDR_W each  forward k and l addresses.
REQ-007 f_read_num  in  RN_W  forward read number.
REQ-008 b_req_valid  in  1  backward pipeline k/l request.
REQ-009 b_addr_k, b_addr_l  in  ADDR_W each  backward k and l addresses.
REQ-010 b_read_num  in  RN_W  backward read number.
REQ-011 f_stall, b_stall  out  1 each  per-requester backpressure.
REQ-012 mem_valid  out  1  memory port request valid.
REQ-013 mem_addr  out  ADDR_W  memory port address.
REQ-014 mem_tag  out  RN_W+2  {src (1=backward), read_num, half (0=k, 1=l)}.
REQ-015 mem_ready  in  1  memory port accepts the request.
REQ-016 resp_valid  in  1  one memory response returned; frees one credit.
REQ-017 busy  out  1  high when state is not IDLE or either holding buffer is full.
REQ-018 err_underflow  out  1  sticky; set when a response arrives with zero outstanding requests.

Function
REQ-019 Each requester SHALL have a one-entry holding buffer for {addr_k, addr_l, read_num}, loaded at an edge where req_valid=1 and its stall=0.
REQ-020 f_stall/b_stall SHALL equal the corresponding buffer-full flag; while stall=1 the block ignores req_valid and the requester holds its inputs stable.
REQ-021 The FSM SHALL have exactly three states: IDLE, ISSUE_K, ISSUE_L.
REQ-022 IDLE: if any buffer is full, grant one buffer and go to ISSUE_K; otherwise remain in IDLE.
REQ-023 Grant SHALL be round-robin: when both buffers are full, grant the source not granted last; after reset, forward has priority.
REQ-024 ISSUE_K: mem_valid=1 with the granted addr_k and half=0, provided outstanding<MAX_OUT; on mem_valid&&mem_ready go to ISSUE_L.
REQ-025 ISSUE_L: mem_valid=1 with the granted addr_l and half=1 under the same credit rule; on the handshake, clear the granted buffer, record the last grant, and go to IDLE.
REQ-026 Once mem_valid is high, it, mem_addr and mem_tag SHALL stay stable until mem_ready; mem_valid SHALL be 0 in IDLE.
REQ-027 Minimum latency: request accepted at edge t -> k presented from cycle t+2 -> l presented from cycle t+3 -> stall deasserted from cycle t+4 (with mem_ready=1 and credits available).
REQ-028 Outstanding counter (6 bits): +1 on each mem handshake, -1 on resp_valid; no change when both occur in the same cycle; never exceeds MAX_OUT.
REQ-029 resp_valid with the counter at 0 SHALL leave the counter at 0 and set err_underflow.
REQ-030 A requester may load a new request in the same cycle its previous one is being issued only if its buffer was already empty; a freed buffer is not reloaded in its freeing cycle.
REQ-031 The outputs of a non-granted buffer SHALL never appear on mem_addr.

Reset
REQ-032 On rst=1 at an edge: state=IDLE, both buffers empty, f_stall=b_stall=0, mem_valid=0, mem_addr=0, mem_tag=0, counter=0, priority=forward, busy=0, err_underflow=0.
REQ-033 A reset mid-transaction SHALL abandon the in-flight request without issuing its remaining half; a request presented during reset SHALL not be captured.

Verification
REQ-034 f_req_valid pulse (addr_k=0x10, addr_l=0x20, read_num=5), mem_ready=1 -> cycle t+2: mem_addr=0x10, tag={0,5,0}; cycle t+3: mem_addr=0x20, tag={0,5,1}; f_stall high during cycles t+1..t+3.
REQ-035 Both requesters valid in the same cycle, continuously -> issue order F,B,F,B; each pair is k then l, never interleaved.
REQ-036 MAX_OUT=2, no responses -> exactly 2 handshakes, then mem_valid=0; one resp_valid -> exactly one more handshake.
REQ-037 mem_ready held low 5 cycles during ISSUE_K -> mem_valid, mem_addr and mem_tag stable for all 5 cycles; ISSUE_L entered only after the ready cycle.
REQ-038 resp_valid with counter=0 -> err_underflow=1 and held; simultaneous handshake and resp_valid at counter=3 -> counter stays 3.
REQ-039 rst asserted in ISSUE_L -> next cycle mem_valid=0, stall=0, busy=0; the l half is never issued.
